// File: rtl/ff_bank_init_sequencer_if.sv
// Control/status bundle between system control and the bank init sequencer.
// All signals are levels sampled on the rising clock edge; there is no valid/ready
// handshake: START/ABORT/HOLD are requests, SR/CE/BUSY/READY/DONE/STATE are registered status.
interface ff_bank_init_sequencer_if #(
  parameter int NUM_BANKS = 4
);
  logic                 START;
  logic                 ABORT;
  logic                 HOLD;
  logic [NUM_BANKS-1:0] SR;
  logic [NUM_BANKS-1:0] CE;
  logic                 BUSY;
  logic                 READY;
  logic                 DONE;
  logic [2:0]           STATE;

  modport master (
    output START, ABORT, HOLD,
    input  SR, CE, BUSY, READY, DONE, STATE
  );

  modport slave (
    input  START, ABORT, HOLD,
    output SR, CE, BUSY, READY, DONE, STATE
  );
endinterface

// File: rtl/ff_bank_init_sequencer.sv
// Clears all register banks, waits for them to settle, then enables them one at a time
// with a fixed stagger. Every output comes straight from a flop so SR can feed async resets.
module ff_bank_init_sequencer #(
  parameter int NUM_BANKS      = 4,
  parameter int SR_CYCLES      = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int STAGGER_CYCLES = 1,
  parameter int CNT_W          = 8
) (
  input  logic                     CK,
  input  logic                     RST_N,
  ff_bank_init_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SETTLE = 3'd2,
    S_ENABLE = 3'd3,
    S_RUN    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] SR_LOAD      = CNT_W'(SR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [NUM_BANKS-1:0] CE_FIRST = NUM_BANKS'(1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_BANKS-1:0] sr_q, sr_d;
  logic [NUM_BANKS-1:0] ce_q, ce_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    ce_d    = ce_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        sr_d = '0;
        ce_d = '0;
        if (bus.START) begin
          state_d = S_CLEAR;
          sr_d    = '1;
          cnt_d   = SR_LOAD;
        end
      end
      S_CLEAR: begin
        if (cnt_q == '0) begin
          sr_d = '0;
          if (SETTLE_CYCLES == 0) begin
            state_d = S_ENABLE;
            ce_d    = CE_FIRST;
            cnt_d   = STAGGER_LOAD;
          end else begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_ENABLE;
          ce_d    = CE_FIRST;
          cnt_d   = STAGGER_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ENABLE: begin
        // CE bits are sticky: each stagger step turns on the next bank up.
        if (cnt_q == '0) begin
          ce_d  = (ce_q << 1) | CE_FIRST;
          cnt_d = STAGGER_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        if (bus.START) begin
          state_d = S_CLEAR;
          sr_d    = '1;
          ce_d    = '0;
          cnt_d   = SR_LOAD;
        end else begin
          ce_d = {NUM_BANKS{~bus.HOLD}};
        end
      end
      default: begin
        state_d = S_IDLE;
        sr_d    = '0;
        ce_d    = '0;
        cnt_d   = '0;
      end
    endcase

    // The cycle the last bank's CE rises is the first RUN cycle (covers NUM_BANKS=1 too).
    if (state_d == S_ENABLE && (&ce_d)) begin
      state_d = S_RUN;
      cnt_d   = '0;
      done_d  = 1'b1;
    end

    if (bus.ABORT) begin
      state_d = S_IDLE;
      sr_d    = '0;
      ce_d    = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end

    busy_d  = (state_d == S_CLEAR) || (state_d == S_SETTLE) || (state_d == S_ENABLE);
    ready_d = (state_d == S_RUN);
  end

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      ce_q    <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      ce_q    <= ce_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.SR    = sr_q;
  assign bus.CE    = ce_q;
  assign bus.BUSY  = busy_q;
  assign bus.READY = ready_q;
  assign bus.DONE  = done_q;
  assign bus.STATE = state_q;

endmodule

// File: tb/tb_ff_bank_init_sequencer.sv
// Bench for ff_bank_init_sequencer: a vector table against the default build plus
// hand-written sequences for single-bank/no-settle and three-bank/wide-stagger builds.
module tb_ff_bank_init_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ff_bank_init_sequencer_if #(.NUM_BANKS(4)) bus_a ();
  ff_bank_init_sequencer_if #(.NUM_BANKS(1)) bus_b ();
  ff_bank_init_sequencer_if #(.NUM_BANKS(3)) bus_c ();

  ff_bank_init_sequencer #(.NUM_BANKS(4)) dut_a (
    .CK(clk), .RST_N(rst_n), .bus(bus_a)
  );
  ff_bank_init_sequencer #(.NUM_BANKS(1), .SETTLE_CYCLES(0), .STAGGER_CYCLES(3)) dut_b (
    .CK(clk), .RST_N(rst_n), .bus(bus_b)
  );
  ff_bank_init_sequencer #(.NUM_BANKS(3), .STAGGER_CYCLES(3)) dut_c (
    .CK(clk), .RST_N(rst_n), .bus(bus_c)
  );

  // Packed observation word: {state[2:0], sr[3:0], ce[3:0], busy, ready, done}
  typedef struct {
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        hold;
    logic [13:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [13:0] exp_q[$];
  int          n_pass  = 0;
  int          n_total = 0;

  function automatic logic [13:0] pack(input logic [2:0] st, input logic [3:0] sr,
                                       input logic [3:0] ce, input logic busy,
                                       input logic ready, input logic done);
    return {st, sr, ce, busy, ready, done};
  endfunction

  task automatic add_vec(input logic r, input logic s, input logic a, input logic h,
                         input logic [13:0] e);
    vec_t v;
    v.rst_n = r; v.start = s; v.abort = a; v.hold = h; v.exp = e;
    vecs.push_back(v);
  endtask

  // Expected default-build output after step k of a START sequence (step 0 samples START).
  function automatic logic [13:0] seq_exp(input int k);
    if (k < 4)  return pack(3'd1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
    if (k < 6)  return pack(3'd2, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    if (k == 6) return pack(3'd3, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0);
    if (k == 7) return pack(3'd3, 4'h0, 4'h3, 1'b1, 1'b0, 1'b0);
    if (k == 8) return pack(3'd3, 4'h0, 4'h7, 1'b1, 1'b0, 1'b0);
    return pack(3'd4, 4'h0, 4'hF, 1'b0, 1'b1, 1'b1);
  endfunction

  // n_steps of a START sequence; start_mask bit k raises START again at step k.
  task automatic add_seq(input int n_steps, input int start_mask);
    for (int k = 0; k < n_steps; k++)
      add_vec(1'b1, (k == 0) || start_mask[k], 1'b0, 1'b0, seq_exp(k));
  endtask

  task automatic add_idle(input int n);
    for (int k = 0; k < n; k++) add_vec(1'b1, 1'b0, 1'b0, 1'b0, 14'h0);
  endtask

  task automatic add_run(input int n, input logic hold);
    for (int k = 0; k < n; k++)
      add_vec(1'b1, 1'b0, 1'b0, hold, pack(3'd4, 4'h0, hold ? 4'h0 : 4'hF, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic pop_cmp(input string name, input logic [13:0] act,
                         input logic [3:0] sr, input logic [3:0] ce);
    logic [13:0] e;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: no expected entry queued, got=%h", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act === e) n_pass++;
      else $display("FAIL %s: got=%h want=%h (state,sr,ce,busy,ready,done)", name, act, e);
    end
    n_total++;
    if ((sr & ce) === 4'h0) n_pass++;
    else $display("FAIL %s sr_ce_overlap: got sr&ce=%h want 0", name, sr & ce);
  endtask

  function automatic logic [13:0] exp_c(input int k);
    if (k < 4)   return pack(3'd1, 4'h7, 4'h0, 1'b1, 1'b0, 1'b0);
    if (k < 6)   return pack(3'd2, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    if (k < 9)   return pack(3'd3, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0);
    if (k < 12)  return pack(3'd3, 4'h0, 4'h3, 1'b1, 1'b0, 1'b0);
    if (k == 12) return pack(3'd4, 4'h0, 4'h7, 1'b0, 1'b1, 1'b1);
    return pack(3'd4, 4'h0, 4'h7, 1'b0, 1'b1, 1'b0);
  endfunction

  initial begin
    logic [13:0] act;
    rst_n = 1'b0;
    bus_a.START = 1'b0; bus_a.ABORT = 1'b0; bus_a.HOLD = 1'b0;
    bus_b.START = 1'b0; bus_b.ABORT = 1'b0; bus_b.HOLD = 1'b0;
    bus_c.START = 1'b0; bus_c.ABORT = 1'b0; bus_c.HOLD = 1'b0;

    // Reset, including START asserted while in reset.
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 14'h0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 14'h0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 14'h0);
    add_idle(2);
    // Full start-up sequence, then RUN with HOLD gating CE.
    add_seq(10, 0);
    add_run(2, 1'b0);
    add_run(3, 1'b1);
    add_run(2, 1'b0);
    // START in RUN restarts at CLEAR with CE dropped in the same cycle.
    add_seq(10, 0);
    add_run(1, 1'b0);
    add_vec(1'b1, 1'b0, 1'b1, 1'b0, 14'h0);
    add_idle(1);
    // START ignored in CLEAR, SETTLE and ENABLE: one clean sequence, single DONE.
    add_seq(10, 32'b1_1010_0110);
    add_run(1, 1'b0);
    add_vec(1'b1, 1'b0, 1'b1, 1'b0, 14'h0);
    // ABORT together with START while CE=3: back to IDLE, then a clean sequence.
    add_seq(8, 0);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0, 14'h0);
    add_idle(2);
    add_seq(10, 0);
    add_vec(1'b1, 1'b0, 1'b1, 1'b0, 14'h0);
    // Reset mid-SETTLE and mid-ENABLE, then a clean sequence.
    add_seq(5, 0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 14'h0);
    add_idle(1);
    add_seq(8, 0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1, 14'h0);
    add_idle(1);
    add_seq(10, 0);
    add_run(1, 1'b0);
    // ABORT in CLEAR, and HOLD in IDLE has no effect.
    add_seq(2, 0);
    add_vec(1'b1, 1'b0, 1'b1, 1'b0, 14'h0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b1, 14'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n       = vecs[i].rst_n;
      bus_a.START = vecs[i].start;
      bus_a.ABORT = vecs[i].abort;
      bus_a.HOLD  = vecs[i].hold;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk); #1;
      act = pack(bus_a.STATE, bus_a.SR, bus_a.CE, bus_a.BUSY, bus_a.READY, bus_a.DONE);
      pop_cmp($sformatf("vec%0d", i), act, bus_a.SR, bus_a.CE);
    end

    // Single bank, no settle: SR for 4 cycles, then CE[0] with DONE straight away.
    @(negedge clk);
    bus_a.START = 1'b0; bus_a.ABORT = 1'b0; bus_a.HOLD = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus_b.START = (k == 0);
      if (k < 4)       exp_q.push_back(pack(3'd1, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0));
      else if (k == 4) exp_q.push_back(pack(3'd4, 4'h0, 4'h1, 1'b0, 1'b1, 1'b1));
      else             exp_q.push_back(pack(3'd4, 4'h0, 4'h1, 1'b0, 1'b1, 1'b0));
      @(posedge clk); #1;
      act = pack(bus_b.STATE, {3'b0, bus_b.SR}, {3'b0, bus_b.CE}, bus_b.BUSY, bus_b.READY, bus_b.DONE);
      pop_cmp($sformatf("one_bank%0d", k), act, {3'b0, bus_b.SR}, {3'b0, bus_b.CE});
    end

    // Three banks with a 3-cycle stagger.
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      bus_b.START = 1'b0;
      bus_c.START = (k == 0);
      exp_q.push_back(exp_c(k));
      @(posedge clk); #1;
      act = pack(bus_c.STATE, {1'b0, bus_c.SR}, {1'b0, bus_c.CE}, bus_c.BUSY, bus_c.READY, bus_c.DONE);
      pop_cmp($sformatf("three_bank%0d", k), act, {1'b0, bus_c.SR}, {1'b0, bus_c.CE});
    end
    @(negedge clk);
    bus_c.START = 1'b0;

    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL leftover_expect: got %0d queued entries want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
